// File: rtl/tap_if.sv
// Serial test-port bundle between a TAP controller and the test equipment / scan chain.
// The slave side is the controller; the master side drives TMS/TDI and the chain's serial output.
interface tap_if #(
   parameter int IR_W = 3
);
   logic            tms;
   logic            tdi;
   logic            bsr_tdo;
   logic            tdo;
   logic            tdo_en;
   logic            shift_dr;
   logic            clock_dr;
   logic            update_dr;
   logic            mode;
   logic [3:0]      state;
   logic [IR_W-1:0] ir;

   modport slave (
      input  tms, tdi, bsr_tdo,
      output tdo, tdo_en, shift_dr, clock_dr, update_dr, mode, state, ir
   );

   modport master (
      output tms, tdi, bsr_tdo,
      input  tdo, tdo_en, shift_dr, clock_dr, update_dr, mode, state, ir
   );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 style TAP controller: 16-state FSM, instruction register, ID and bypass
// data registers, and gated ClockDR/UpdateDR strobes for an external boundary-scan chain.
module tap_controller #(
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
   parameter int          IR_W       = 3
) (
   input  logic  i_tck,
   input  logic  i_rst,
   tap_if.slave  io_tap
);
   localparam logic [3:0] S_TLR   = 4'hF;
   localparam logic [3:0] S_RTI   = 4'hC;
   localparam logic [3:0] S_SELDR = 4'h7;
   localparam logic [3:0] S_CAPDR = 4'h6;
   localparam logic [3:0] S_SHDR  = 4'h2;
   localparam logic [3:0] S_EX1DR = 4'h1;
   localparam logic [3:0] S_PAUDR = 4'h3;
   localparam logic [3:0] S_EX2DR = 4'h0;
   localparam logic [3:0] S_UPDDR = 4'h5;
   localparam logic [3:0] S_SELIR = 4'h4;
   localparam logic [3:0] S_CAPIR = 4'hE;
   localparam logic [3:0] S_SHIR  = 4'hA;
   localparam logic [3:0] S_EX1IR = 4'h9;
   localparam logic [3:0] S_PAUIR = 4'hB;
   localparam logic [3:0] S_EX2IR = 4'h8;
   localparam logic [3:0] S_UPDIR = 4'hD;

   // Codes not listed here fall through to the bypass register.
   localparam logic [IR_W-1:0] I_EXTEST = IR_W'(0);
   localparam logic [IR_W-1:0] I_SAMPLE = IR_W'(1);
   localparam logic [IR_W-1:0] I_IDCODE = IR_W'(2);
   localparam logic [IR_W-1:0] I_CAPT   = IR_W'(1);

   logic [3:0]      r_state;
   logic [3:0]      w_state_next;
   logic [IR_W-1:0] r_ir;
   logic [IR_W-1:0] r_ir_sr;
   logic [31:0]     r_id;
   logic            r_bypass;
   logic            r_shift_dr;
   logic            r_en_clk;
   logic            r_tdo;
   logic            r_tdo_en;
   logic            w_bsr_sel;
   logic            w_id_sel;
   logic            w_dr_tdo;

   assign w_bsr_sel = (r_ir == I_EXTEST) || (r_ir == I_SAMPLE);
   assign w_id_sel  = (r_ir == I_IDCODE);
   assign w_dr_tdo  = w_bsr_sel ? io_tap.bsr_tdo : (w_id_sel ? r_id[0] : r_bypass);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_TLR:   w_state_next = io_tap.tms ? S_TLR   : S_RTI;
         S_RTI:   w_state_next = io_tap.tms ? S_SELDR : S_RTI;
         S_SELDR: w_state_next = io_tap.tms ? S_SELIR : S_CAPDR;
         S_SELIR: w_state_next = io_tap.tms ? S_TLR   : S_CAPIR;
         S_CAPDR: w_state_next = io_tap.tms ? S_EX1DR : S_SHDR;
         S_SHDR:  w_state_next = io_tap.tms ? S_EX1DR : S_SHDR;
         S_EX1DR: w_state_next = io_tap.tms ? S_UPDDR : S_PAUDR;
         S_PAUDR: w_state_next = io_tap.tms ? S_EX2DR : S_PAUDR;
         S_EX2DR: w_state_next = io_tap.tms ? S_UPDDR : S_SHDR;
         S_UPDDR: w_state_next = io_tap.tms ? S_SELDR : S_RTI;
         S_CAPIR: w_state_next = io_tap.tms ? S_EX1IR : S_SHIR;
         S_SHIR:  w_state_next = io_tap.tms ? S_EX1IR : S_SHIR;
         S_EX1IR: w_state_next = io_tap.tms ? S_UPDIR : S_PAUIR;
         S_PAUIR: w_state_next = io_tap.tms ? S_EX2IR : S_PAUIR;
         S_EX2IR: w_state_next = io_tap.tms ? S_UPDIR : S_SHIR;
         S_UPDIR: w_state_next = io_tap.tms ? S_SELDR : S_RTI;
         default: w_state_next = S_TLR;
      endcase
   end

   // Rising TCK: state advance plus capture/shift of the internal registers.
   always_ff @(posedge i_tck or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_TLR;
         r_ir_sr  <= I_CAPT;
         r_id     <= IDCODE_VAL;
         r_bypass <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_CAPIR: r_ir_sr <= I_CAPT;
            S_SHIR:  r_ir_sr <= {io_tap.tdi, r_ir_sr[IR_W-1:1]};
            S_CAPDR: begin
               r_bypass <= 1'b0;
               if (w_id_sel) r_id <= IDCODE_VAL;
            end
            S_SHDR: begin
               r_bypass <= io_tap.tdi;
               if (w_id_sel) r_id <= {io_tap.tdi, r_id[31:1]};
            end
            default: ;
         endcase
      end
   end

   // Falling TCK: outputs and gating enables settle half a cycle before the next rising edge.
   always_ff @(negedge i_tck or posedge i_rst) begin
      if (i_rst) begin
         r_ir       <= I_IDCODE;
         r_shift_dr <= 1'b0;
         r_en_clk   <= 1'b0;
         r_tdo      <= 1'b0;
         r_tdo_en   <= 1'b0;
      end else begin
         if (r_state == S_TLR)
            r_ir <= I_IDCODE;
         else if (r_state == S_UPDIR)
            r_ir <= r_ir_sr;
         r_shift_dr <= (r_state == S_SHDR);
         r_en_clk   <= ((r_state == S_CAPDR) || (r_state == S_SHDR)) && w_bsr_sel;
         r_tdo_en   <= (r_state == S_SHIR) || (r_state == S_SHDR);
         case (r_state)
            S_SHIR:  r_tdo <= r_ir_sr[0];
            S_SHDR:  r_tdo <= w_dr_tdo;
            default: r_tdo <= 1'b0;
         endcase
      end
   end

   assign io_tap.clock_dr  = i_tck & r_en_clk;
   assign io_tap.update_dr = ~i_tck & (r_state == S_UPDDR) & w_bsr_sel;
   assign io_tap.shift_dr  = r_shift_dr;
   assign io_tap.mode      = (r_ir == I_EXTEST);
   assign io_tap.tdo       = r_tdo;
   assign io_tap.tdo_en    = r_tdo_en;
   assign io_tap.state     = r_state;
   assign io_tap.ir        = r_ir;
endmodule
